// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-master RAM port arbiter.
// Contents:
//   NUM_MASTERS - number of masters sharing the target port
//   mst_id_e    - master identifier, stored in the read-ID FIFO
package rvcore_bus_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [0:0] {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } mst_id_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Core bus: req/write/wstrb/addr/wdata forward, ready/rvalid/rdata back.
// Modports:
//   master - issues requests (req, write, wstrb, addr, wdata out; ready, rvalid, rdata in)
//   slave  - serves requests (the reverse directions)
interface rvcore_bus_if #(
  parameter int XLEN = 32
) ();
  logic              req;
  logic              write;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              ready;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, write, wstrb, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, write, wstrb, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter_fifo.sv
// bus_id_fifo: small synchronous FIFO holding the master ID of each accepted read.
// Ports:
//   clk, rst_b  - clock, asynchronous active-low reset
//   push, din   - write an entry (ignored when full unless a pop happens in the same cycle)
//   pop, dout   - remove the head entry (ignored when empty); dout shows the head
//   full, empty - status
//   count       - number of stored entries
module bus_id_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A pop frees the head slot this cycle, so a push may land even when full.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port target bus between the instruction
// master (m0) and the data master (m1) with round-robin arbitration. Accepted
// reads are queued by master ID so each in-order response is steered back to
// its issuer with no added latency.
// Ports:
//   clk, rst_b        - clock, asynchronous active-low reset
//   m0, m1            - master-facing buses (instr, data)
//   s                 - target-facing bus
//   err_unexp_rvalid  - sticky: target responded with no read outstanding
//   outstanding       - accepted reads still awaiting rvalid
module ram_port_arbiter
  import rvcore_bus_pkg::*;
#(
  parameter  int XLEN            = 32,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk,
  input  logic            rst_b,
  rvcore_bus_if.slave     m0,
  rvcore_bus_if.slave     m1,
  rvcore_bus_if.master    s,
  output logic            err_unexp_rvalid,
  output logic [CW-1:0]   outstanding
);

  mst_id_e           r_last_grant;
  logic              r_err;
  mst_id_e           w_gnt_id;
  logic              w_gnt_valid;
  logic              w_gnt_write;
  logic [XLEN-1:0]   w_gnt_addr;
  logic [XLEN-1:0]   w_gnt_wdata;
  logic [XLEN/8-1:0] w_gnt_wstrb;
  logic              w_blk;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [0:0]        w_head_raw;
  mst_id_e           w_head;
  logic [CW-1:0]     w_count;

  // Round-robin: on a tie the master that did not win last time goes first.
  // With no request the payload defaults to m0.
  always_comb begin
    w_gnt_valid = m0.req | m1.req;
    w_gnt_id    = MST_INSTR;
    if (m0.req && m1.req) begin
      w_gnt_id = (r_last_grant == MST_INSTR) ? MST_DATA : MST_INSTR;
    end else if (m1.req) begin
      w_gnt_id = MST_DATA;
    end
  end

  always_comb begin
    w_gnt_write = m0.write;
    w_gnt_addr  = m0.addr;
    w_gnt_wdata = m0.wdata;
    w_gnt_wstrb = m0.wstrb;
    if (w_gnt_id == MST_DATA) begin
      w_gnt_write = m1.write;
      w_gnt_addr  = m1.addr;
      w_gnt_wdata = m1.wdata;
      w_gnt_wstrb = m1.wstrb;
    end
  end

  // A full ID queue stalls new requests unless a response pops it this cycle.
  assign w_blk = w_full & ~s.rvalid;

  assign s.req   = w_gnt_valid & ~w_blk;
  assign s.write = w_gnt_write;
  assign s.addr  = w_gnt_addr;
  assign s.wdata = w_gnt_wdata;
  assign s.wstrb = w_gnt_wstrb;

  assign m0.ready = w_gnt_valid & (w_gnt_id == MST_INSTR) & s.ready & ~w_blk;
  assign m1.ready = w_gnt_valid & (w_gnt_id == MST_DATA)  & s.ready & ~w_blk;

  assign w_accept = s.req & s.ready;
  assign w_push   = w_accept & ~w_gnt_write;
  assign w_pop    = s.rvalid & ~w_empty;

  bus_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (w_push),
    .din   (w_gnt_id),
    .pop   (w_pop),
    .dout  (w_head_raw),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_head = mst_id_e'(w_head_raw);

  assign m0.rvalid = w_pop & (w_head == MST_INSTR);
  assign m1.rvalid = w_pop & (w_head == MST_DATA);
  assign m0.rdata  = m0.rvalid ? s.rdata : '0;
  assign m1.rdata  = m1.rvalid ? s.rdata : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last_grant <= MST_DATA;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_gnt_id;
      if (s.rvalid && w_empty) r_err <= 1'b1;
    end
  end

  assign err_unexp_rvalid = r_err;
  assign outstanding      = w_count;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port RAM/target bus between the instruction master (m0) and the data master (m1).
- All ports use the core's req/write/wstrb/addr/wdata/ready/rvalid/rdata protocol.
- Arbitration is round-robin. Accepted reads are tracked in an ID FIFO so that each read response (rvalid/rdata) returns to the master that issued it.
- Sits between the core and a single-port memory for FPGA builds where a dual-port RAM is unavailable.

Parameters:
- XLEN, 32, data/address width
- MAX_OUTSTANDING, 2, maximum accepted reads awaiting rvalid; power of 2, ≥1

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- m0_req, m0_write  in  1  instr master request / write
- m0_wstrb  in  XLEN/8  byte strobes
- m0_addr, m0_wdata  in  XLEN  address / write data
- m0_ready  out  1  request accepted this cycle
- m0_rvalid  out  1  read data valid
- m0_rdata  out  XLEN  read data
- m1_*  (same set as m0_*)  data master
- s_req, s_write  out  1  to target
- s_wstrb  out  XLEN/8  to target
- s_addr, s_wdata  out  XLEN  to target
- s_ready  in  1  target accepts
- s_rvalid  in  1  target read response
- s_rdata  in  XLEN  target read data
- err_unexp_rvalid  out  1  sticky: s_rvalid seen with no outstanding read
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight

Behaviour:
- Clock and reset: single clock clk; rst_b is asynchronous assert, active-low.
- Reset values:
  - last_grant = m1 (first tie goes to m0).
  - ID FIFO empty; outstanding = 0; err_unexp_rvalid = 0.
  - All m*_rvalid = 0.
- Grant (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master ≠ last_grant.
  - Neither requesting: no grant; s_req = 0; s_* payload driven from m0.
- Block condition: blk = fifo_full & ~(s_rvalid). A pop in the same cycle frees a slot.
- Target request: s_req = granted_req & ~blk. s_write/s_wstrb/s_addr/s_wdata are muxed from the granted master.
- Ready:
  - m_ready of the granted master = s_ready & ~blk.
  - m_ready of the non-granted master = 0. Never assert ready to a non-requesting master.
- Accept: a master request is accepted when m_req & m_ready. On accept:
  - last_grant <= accepted master.
  - If it is a read (~write), push the master ID into the FIFO.
  - Writes do not push and never produce rvalid.
- Response:
  - s_rvalid with FIFO non-empty: pop the head; drive rvalid=1 and rdata=s_rdata to the head master in the same cycle (zero added latency).
  - The other master gets rvalid=0 and rdata=0.
- Latency: arbiter adds 0 cycles on both request and response paths. Read latency equals the target latency.
- Simultaneous push and pop: both take effect; outstanding unchanged. Allowed when full.
- Response ordering: responses are strictly in acceptance order. The target must return in order.
- Unexpected response: s_rvalid with FIFO empty:
  - err_unexp_rvalid <= 1 (sticky until reset).
  - Response is dropped; no master rvalid.
- Held requests: a master held off by arbitration or blk keeps its req/payload stable. The arbiter does not latch the payload.
- Fairness: with both masters requesting continuously and s_ready=1, grants alternate every cycle.
- Reset mid-operation: FIFO and outstanding clear immediately. In-flight responses are lost (the target is reset by the same rst_b).

Decomposition:
- Package rvcore_bus_pkg: master-ID typedef (MST_INSTR=0, MST_DATA=1) and NUM_MASTERS=2.
- Sub-module bus_id_fifo: parameterized depth/width synchronous FIFO with push/pop/full/empty/count. Same-cycle push+pop is legal when full. Pop when empty is ignored.

Test Plan:
- Single read: m1 read addr 0x10, target rdata 0x0000_00AA one cycle later → m1_ready=1 in cycle 0; m1_rvalid=1 with 0xAA in cycle 1; m0_rvalid=0; outstanding 1→0.
- Contention: m0 and m1 both hold reads from reset with s_ready=1 → grants in order m0, m1, m0, m1. Each rvalid is routed to the correct master with distinct data (0x100+n).
- Full stall: MAX_OUTSTANDING=2, target delays rvalid 3 cycles, m0 issues 3 reads → third ready=0 until the first rvalid cycle, where it is accepted (push+pop); outstanding stays 2.
- Write: m1 write 0xDEADBEEF, wstrb 0x3 → s_wstrb=0x3; no FIFO push; no rvalid to either master.
- Unexpected response: s_rvalid=1 with outstanding=0 → err_unexp_rvalid=1 next cycle and stays 1; both m*_rvalid stay 0.
- Reset mid-flight: 2 reads outstanding, then rst_b=0 for 1 cycle → outstanding=0 and err=0 asynchronously. The next tie grants m0.
